// File: rtl/neighbor_table_update_pkg.sv
// Shared memory map, sizes and result codes for the neighbour table writer and the
// next-hop selector that reads the same table.
package neighbor_table_update_pkg;

  localparam int unsigned WORD_WIDTH    = 16;
  localparam int unsigned MAX_NEIGHBORS = 64;
  localparam int unsigned MAX_SINKS     = 16;
  localparam int unsigned NBR_IDX_W     = 7;
  localparam int unsigned SINK_IDX_W    = 5;

  localparam logic [WORD_WIDTH-1:0] EMPTY_ID     = 16'hFFFF;
  localparam logic [WORD_WIDTH-1:0] SINK_BASE    = 16'h0008;
  localparam logic [WORD_WIDTH-1:0] NBR_ID_BASE  = 16'h0048;
  localparam logic [WORD_WIDTH-1:0] CLUSTER_BASE = 16'h00C8;
  localparam logic [WORD_WIDTH-1:0] BATT_BASE    = 16'h0148;
  localparam logic [WORD_WIDTH-1:0] QVAL_BASE    = 16'h01C8;

  typedef enum logic [1:0] {
    RES_NONE     = 2'b00,
    RES_UPDATED  = 2'b01,
    RES_INSERTED = 2'b10,
    RES_DROPPED  = 2'b11
  } result_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WR_ID,
    ST_WR_CL,
    ST_WR_BAT,
    ST_WR_Q,
    ST_SINK_SCAN,
    ST_SINK_WR,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] src_id;
    logic [WORD_WIDTH-1:0] cluster_id;
    logic [WORD_WIDTH-1:0] battery;
    logic [WORD_WIDTH-1:0] qvalue;
    logic                  is_sink;
  } beacon_t;

  // Byte address of 16-bit entry idx in an array starting at base (mod 2^16).
  function automatic logic [WORD_WIDTH-1:0] slot_addr(input logic [WORD_WIDTH-1:0] base,
                                                      input logic [NBR_IDX_W-1:0]  idx);
    return base + {8'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/neighbor_table_update.sv
// Writes one received beacon into the shared neighbour table (update or first-free insert)
// and records sink neighbours in the knownSinks list.
module neighbor_table_update
  import neighbor_table_update_pkg::*;
(
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [WORD_WIDTH-1:0] pkt_src_id,
  input  logic [WORD_WIDTH-1:0] pkt_cluster_id,
  input  logic [WORD_WIDTH-1:0] pkt_battery,
  input  logic [WORD_WIDTH-1:0] pkt_qvalue,
  input  logic                  pkt_is_sink,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  done,
  output logic [1:0]            result,
  output logic [WORD_WIDTH-1:0] neighbor_count
);

  state_e                  r_state;
  beacon_t                 r_bcn;
  logic [NBR_IDX_W-1:0]    r_i;
  logic [NBR_IDX_W-1:0]    r_idx;
  logic [NBR_IDX_W-1:0]    r_free_idx;
  logic                    r_free_vld;
  logic [SINK_IDX_W-1:0]   r_j;
  logic [SINK_IDX_W-1:0]   r_sfree_idx;
  logic                    r_sfree_vld;
  logic                    r_insert;
  logic                    r_pkt_ready;
  logic [WORD_WIDTH-1:0]   r_address;
  logic                    r_wr_en;
  logic [WORD_WIDTH-1:0]   r_data_out;
  logic                    r_done;
  result_e                 r_result;
  logic [WORD_WIDTH-1:0]   r_count;

  logic                    w_hit;
  logic                    w_empty;
  logic                    w_last_nbr;
  logic                    w_last_sink;
  logic                    w_free_any;
  logic [NBR_IDX_W-1:0]    w_free_slot;
  logic                    w_sfree_any;
  logic [SINK_IDX_W-1:0]   w_sfree_slot;
  result_e                 w_fin_result;

  assign w_hit        = (data_in == r_bcn.src_id);
  assign w_empty      = (data_in == EMPTY_ID);
  assign w_last_nbr   = (r_i == NBR_IDX_W'(MAX_NEIGHBORS - 1));
  assign w_last_sink  = (r_j == SINK_IDX_W'(MAX_SINKS - 1));
  // The slot read this cycle counts as free too, so the last entry can be claimed.
  assign w_free_any   = r_free_vld | w_empty;
  assign w_free_slot  = r_free_vld ? r_free_idx : r_i;
  assign w_sfree_any  = r_sfree_vld | w_empty;
  assign w_sfree_slot = r_sfree_vld ? r_sfree_idx : r_j;
  assign w_fin_result = r_insert ? RES_INSERTED : RES_UPDATED;

  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_bcn       <= '0;
      r_i         <= '0;
      r_idx       <= '0;
      r_free_idx  <= '0;
      r_free_vld  <= 1'b0;
      r_j         <= '0;
      r_sfree_idx <= '0;
      r_sfree_vld <= 1'b0;
      r_insert    <= 1'b0;
      r_pkt_ready <= 1'b1;
      r_address   <= NBR_ID_BASE;
      r_wr_en     <= 1'b0;
      r_data_out  <= '0;
      r_done      <= 1'b0;
      r_result    <= RES_NONE;
      r_count     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (pkt_valid && r_pkt_ready) begin
            r_bcn.src_id     <= pkt_src_id;
            r_bcn.cluster_id <= pkt_cluster_id;
            r_bcn.battery    <= pkt_battery;
            r_bcn.qvalue     <= pkt_qvalue;
            r_bcn.is_sink    <= pkt_is_sink;
            r_i              <= '0;
            r_free_vld       <= 1'b0;
            r_pkt_ready      <= 1'b0;
            r_address        <= NBR_ID_BASE;
            if (pkt_src_id == EMPTY_ID) begin
              r_result <= RES_DROPPED;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            r_idx      <= r_i;
            r_insert   <= 1'b0;
            r_address  <= slot_addr(CLUSTER_BASE, r_i);
            r_data_out <= r_bcn.cluster_id;
            r_wr_en    <= 1'b1;
            r_state    <= ST_WR_CL;
          end else if (w_last_nbr) begin
            if (w_free_any) begin
              r_idx      <= w_free_slot;
              r_insert   <= 1'b1;
              r_address  <= slot_addr(NBR_ID_BASE, w_free_slot);
              r_data_out <= r_bcn.src_id;
              r_wr_en    <= 1'b1;
              r_state    <= ST_WR_ID;
            end else begin
              r_result <= RES_DROPPED;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end
          end else begin
            if (w_empty && !r_free_vld) begin
              r_free_idx <= r_i;
              r_free_vld <= 1'b1;
            end
            r_i       <= r_i + 7'd1;
            r_address <= slot_addr(NBR_ID_BASE, r_i + 7'd1);
          end
        end
        ST_WR_ID: begin
          if (r_count < WORD_WIDTH'(MAX_NEIGHBORS)) r_count <= r_count + 16'd1;
          r_address  <= slot_addr(CLUSTER_BASE, r_idx);
          r_data_out <= r_bcn.cluster_id;
          r_wr_en    <= 1'b1;
          r_state    <= ST_WR_CL;
        end
        ST_WR_CL: begin
          r_address  <= slot_addr(BATT_BASE, r_idx);
          r_data_out <= r_bcn.battery;
          r_wr_en    <= 1'b1;
          r_state    <= ST_WR_BAT;
        end
        ST_WR_BAT: begin
          r_address  <= slot_addr(QVAL_BASE, r_idx);
          r_data_out <= r_bcn.qvalue;
          r_wr_en    <= 1'b1;
          r_state    <= ST_WR_Q;
        end
        ST_WR_Q: begin
          if (r_bcn.is_sink) begin
            r_j         <= '0;
            r_sfree_vld <= 1'b0;
            r_address   <= SINK_BASE;
            r_state     <= ST_SINK_SCAN;
          end else begin
            r_result <= w_fin_result;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_SINK_SCAN: begin
          if (w_hit) begin
            r_result <= w_fin_result;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (w_last_sink) begin
            if (w_sfree_any) begin
              r_address  <= slot_addr(SINK_BASE, {2'b00, w_sfree_slot});
              r_data_out <= r_bcn.src_id;
              r_wr_en    <= 1'b1;
              r_state    <= ST_SINK_WR;
            end else begin
              r_result <= w_fin_result;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end
          end else begin
            if (w_empty && !r_sfree_vld) begin
              r_sfree_idx <= r_j;
              r_sfree_vld <= 1'b1;
            end
            r_j       <= r_j + 5'd1;
            r_address <= slot_addr(SINK_BASE, {2'b00, r_j + 5'd1});
          end
        end
        ST_SINK_WR: begin
          r_result <= w_fin_result;
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_pkt_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pkt_ready      = r_pkt_ready;
  assign address        = r_address;
  assign wr_en          = r_wr_en;
  assign data_out       = r_data_out;
  assign done           = r_done;
  assign result         = r_result;
  assign neighbor_count = r_count;

endmodule

// File: tb/tb_neighbor_table_update.sv
// Directed bench for neighbor_table_update: table-level model plus per-cycle write/result checker.
module tb_neighbor_table_update;

  localparam logic [15:0] EMPTY = 16'hFFFF;
  localparam logic [15:0] SINKB = 16'h0008;
  localparam logic [15:0] IDB   = 16'h0048;
  localparam logic [15:0] CLB   = 16'h00C8;
  localparam logic [15:0] BATB  = 16'h0148;
  localparam logic [15:0] QB    = 16'h01C8;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clock, nrst;
  logic        pkt_valid, pkt_ready, pkt_is_sink;
  logic [15:0] pkt_src_id, pkt_cluster_id, pkt_battery, pkt_qvalue;
  logic [15:0] data_in, address, data_out, neighbor_count;
  logic        wr_en, done;
  logic [1:0]  result;

  logic [15:0] mem  [512];
  logic [15:0] mmem [512];
  logic [15:0] img  [512];
  logic        load;
  wr_t         expq [$];
  logic [1:0]  exp_result;
  int          exp_count;
  int          total, bad;

  neighbor_table_update dut (
    .clock(clock), .nrst(nrst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_src_id(pkt_src_id), .pkt_cluster_id(pkt_cluster_id), .pkt_battery(pkt_battery),
    .pkt_qvalue(pkt_qvalue), .pkt_is_sink(pkt_is_sink), .data_in(data_in),
    .address(address), .wr_en(wr_en), .data_out(data_out), .done(done),
    .result(result), .neighbor_count(neighbor_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Async-read, sync-write memory; the bench loads whole images through the same port.
  assign data_in = mem[address[9:1]];
  always @(posedge clock) begin
    if (load) begin
      for (int k = 0; k < 512; k++) mem[k] <= img[k];
    end else if (wr_en) begin
      mem[address[9:1]] <= data_out;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  function automatic int widx(input logic [15:0] base, input int k);
    logic [15:0] a;
    a = base + 16'(2 * k);
    return int'(a[9:1]);
  endfunction

  task automatic push(input logic [15:0] base, input int k, input logic [15:0] d);
    wr_t w;
    w.a = base + 16'(2 * k);
    w.d = d;
    expq.push_back(w);
    mmem[w.a[9:1]] = d;
  endtask

  // Table-level expectation: writes, result, latency (edges after accept until done).
  task automatic model(input logic [15:0] s, c, b, q, input logic sk, output int n);
    int hit, fr, sh, sf;
    hit = -1; fr = -1;
    if (s == EMPTY) begin
      exp_result = 2'b11; n = 0; return;
    end
    for (int k = 0; k < 64; k++) begin
      if (hit < 0 && mmem[widx(IDB, k)] == s) hit = k;
      if (fr < 0 && mmem[widx(IDB, k)] == EMPTY) fr = k;
    end
    if (hit >= 0) begin
      exp_result = 2'b01; n = hit + 4;
      push(CLB, hit, c); push(BATB, hit, b); push(QB, hit, q);
    end else if (fr >= 0) begin
      exp_result = 2'b10; n = 68;
      push(IDB, fr, s); push(CLB, fr, c); push(BATB, fr, b); push(QB, fr, q);
      if (exp_count < 64) exp_count++;
    end else begin
      exp_result = 2'b11; n = 64; return;
    end
    if (sk) begin
      sh = -1; sf = -1;
      for (int j = 0; j < 16; j++) begin
        if (sh < 0 && mmem[widx(SINKB, j)] == s) sh = j;
        if (sf < 0 && mmem[widx(SINKB, j)] == EMPTY) sf = j;
      end
      if (sh >= 0) n += sh + 1;
      else if (sf >= 0) begin n += 17; push(SINKB, sf, s); end
      else n += 16;
    end
  endtask

  task automatic load_image();
    for (int k = 0; k < 512; k++) img[k] = mmem[k];
    load = 1'b1;
    @(posedge clock);
    #1 load = 1'b0;
    @(negedge clock);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 512; k++) mmem[k] = EMPTY;
  endtask

  task automatic chk_mem(input string nm);
    int m;
    m = 0;
    for (int k = 0; k < 512; k++) if (mem[k] !== mmem[k]) m++;
    chk(nm, m, 0);
  endtask

  task automatic drive(input logic [15:0] s, c, b, q, input logic sk);
    int g;
    g = 0;
    while (pkt_ready !== 1'b1 && g < 200) begin @(negedge clock); g++; end
    if (g >= 200) chk("ready_timeout", 1, 0);
    pkt_src_id = s; pkt_cluster_id = c; pkt_battery = b; pkt_qvalue = q;
    pkt_is_sink = sk; pkt_valid = 1'b1;
    @(posedge clock);
    #1;
    pkt_valid = 1'b0;
    pkt_src_id = 16'h1234; pkt_cluster_id = 16'h5678; pkt_battery = 16'h9ABC;
    pkt_qvalue = 16'hDEF0; pkt_is_sink = ~sk;
  endtask

  task automatic send(input string nm, input logic [15:0] s, c, b, q, input logic sk,
                      output int n);
    int en;
    model(s, c, b, q, sk, en);
    drive(s, c, b, q, sk);
    n = 0;
    forever begin
      @(negedge clock);
      if (done === 1'b1) break;
      n++;
      if (n > 300) begin chk({nm, "_done_timeout"}, 1, 0); break; end
    end
    chk({nm, "_latency"}, n, en);
    chk({nm, "_count"}, neighbor_count, exp_count);
    @(negedge clock);
    chk({nm, "_done_pulse"}, done, 1'b0);
    chk({nm, "_ready_back"}, pkt_ready, 1'b1);
    chk({nm, "_pending_writes"}, expq.size(), 0);
    expq.delete();
    chk_mem({nm, "_mem"});
  endtask

  // Every write must be the next one the model expects; every done carries the model result.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", address, data_out);
      end else begin
        wr_t w;
        w = expq.pop_front();
        chk("wr_addr", address, w.a);
        chk("wr_data", data_out, w.d);
      end
    end
    if (done === 1'b1) chk("done_result", result, exp_result);
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    total = 0; bad = 0; exp_count = 0; exp_result = 2'b00; load = 1'b0;
    nrst = 1'b0; pkt_valid = 1'b0; pkt_is_sink = 1'b0;
    pkt_src_id = '0; pkt_cluster_id = '0; pkt_battery = '0; pkt_qvalue = '0;
    clear_model();
    load_image();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", pkt_ready, 1'b1);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 2'b00);
    chk("rst_address", address, 16'h0048);
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_count", neighbor_count, 16'h0000);
    nrst = 1'b1;
    @(negedge clock);

    // Insert into an empty table.
    send("t1", 16'd5, 16'd2, 16'h3C00, 16'h3800, 1'b0, n);
    chk("t1_lat_lit", n, 68);
    chk("t1_id", mem[16'h0048 >> 1], 16'd5);
    chk("t1_cl", mem[16'h00C8 >> 1], 16'd2);
    chk("t1_bat", mem[16'h0148 >> 1], 16'h3C00);
    chk("t1_q", mem[16'h01C8 >> 1], 16'h3800);
    chk("t1_res", result, 2'b10);
    chk("t1_cnt", neighbor_count, 16'd1);

    // Update the same neighbour.
    send("t2", 16'd5, 16'd2, 16'h3C00, 16'h3000, 1'b0, n);
    chk("t2_q", mem[16'h01C8 >> 1], 16'h3000);
    chk("t2_res", result, 2'b01);
    chk("t2_cnt", neighbor_count, 16'd1);
    chk("t2_lat_lit", n, 4);

    // EMPTY_ID source is dropped without memory access.
    send("te", 16'hFFFF, 16'd1, 16'd1, 16'd1, 1'b1, n);
    chk("te_res", result, 2'b11);
    chk("te_lat_lit", n, 0);

    // Full table drops the beacon.
    clear_model();
    for (int k = 0; k < 64; k++) mmem[widx(IDB, k)] = 16'(100 + k);
    load_image();
    send("t3", 16'd7, 16'd1, 16'd2, 16'd3, 1'b1, n);
    chk("t3_res", result, 2'b11);
    chk("t3_lat_lit", n, 64);

    // Only the last slot is free.
    mmem[widx(IDB, 63)] = EMPTY;
    load_image();
    send("t3b", 16'd7, 16'd1, 16'd2, 16'd3, 1'b0, n);
    chk("t3b_id63", mem[widx(IDB, 63)], 16'd7);
    chk("t3b_res", result, 2'b10);

    // Sink insert, then repeat without a second sink write.
    clear_model();
    load_image();
    send("t4", 16'd9, 16'd4, 16'd5, 16'd6, 1'b1, n);
    chk("t4_sink0", mem[16'h0008 >> 1], 16'd9);
    chk("t4_lat_lit", n, 85);
    send("t4r", 16'd9, 16'd4, 16'd5, 16'd7, 1'b1, n);
    chk("t4r_lat_lit", n, 5);
    chk("t4r_sink1", mem[16'h000A >> 1], 16'hFFFF);

    // Matching slot beats an earlier empty slot.
    clear_model();
    for (int k = 0; k < 64; k++) mmem[widx(IDB, k)] = 16'(300 + k);
    mmem[widx(IDB, 3)]  = EMPTY;
    mmem[widx(IDB, 10)] = 16'd12;
    load_image();
    send("t5", 16'd12, 16'h21, 16'h22, 16'h23, 1'b0, n);
    chk("t5_cl10", mem[widx(CLB, 10)], 16'h21);
    chk("t5_id3", mem[widx(IDB, 3)], 16'hFFFF);
    chk("t5_cl3", mem[widx(CLB, 3)], 16'hFFFF);
    chk("t5_lat_lit", n, 14);

    // Reset while the battery write is on the bus.
    clear_model();
    mmem[widx(IDB, 0)] = 16'd5;
    load_image();
    model(16'd5, 16'h31, 16'h32, 16'h33, 1'b0, n);
    mmem[widx(QB, 0)] = EMPTY;
    exp_count = 0;
    drive(16'd5, 16'h31, 16'h32, 16'h33, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1 nrst = 1'b0;
    @(posedge clock);
    #1;
    chk("t6_wr_en", wr_en, 1'b0);
    chk("t6_address", address, 16'h0048);
    chk("t6_ready", pkt_ready, 1'b1);
    chk("t6_done", done, 1'b0);
    chk("t6_result", result, 2'b00);
    chk("t6_data_out", data_out, 16'h0000);
    chk("t6_count", neighbor_count, 16'h0000);
    @(posedge clock);
    #1 nrst = 1'b1;
    chk("t6_q_untouched", mem[widx(QB, 0)], 16'hFFFF);
    chk("t6_abandoned", expq.size(), 1);
    expq.delete();
    chk_mem("t6_mem");
    @(negedge clock);
    send("t6n", 16'd20, 16'h41, 16'h42, 16'h43, 1'b0, n);
    chk("t6n_id1", mem[widx(IDB, 1)], 16'd20);
    chk("t6n_cnt", neighbor_count, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
